// File: rtl/multicycle_control_fsm.sv
// Multi-cycle RV32I control sequencer: FETCH/DECODE/EXEC/MEM/WB with latched instruction fields.
// Latency: ALU/JAL/JALR/LUI/AUIPC 4 cycles, load 5, store 4, branch 3 (zero-wait memory).
// Backpressure: waits in FETCH/MEM for imem_ready/dmem_ready, bounded by TIMEOUT before TRAP.
module multicycle_control_fsm #(
   parameter int TIMEOUT         = 255,
   parameter int CNT_W           = 32,
   parameter bit TRAP_ON_ILLEGAL = 1'b1
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      instr,
   input  logic             imem_ready,
   input  logic             dmem_ready,
   input  logic             branch_taken,
   output logic             imem_req,
   output logic             dmem_req,
   output logic             ir_write,
   output logic             mem_read,
   output logic             mem_write,
   output logic [3:0]       alu_ctrl,
   output logic             alu_src,
   output logic [2:0]       branch_ctrl,
   output logic [1:0]       wb_sel,
   output logic             reg_write,
   output logic             pc_write,
   output logic [1:0]       pc_sel,
   output logic             busy,
   output logic             trap,
   output logic [CNT_W-1:0] instret
);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_IMM    = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;

   localparam logic [3:0] ALU_ADD = 4'd0,  ALU_SUB  = 4'd1,  ALU_AND  = 4'd2, ALU_OR  = 4'd3;
   localparam logic [3:0] ALU_XOR = 4'd4,  ALU_SLL  = 4'd5,  ALU_SRL  = 4'd6, ALU_SRA = 4'd7;
   localparam logic [3:0] ALU_SLT = 4'd8,  ALU_SLTU = 4'd9,  ALU_PASS = 4'd10;
   localparam logic [3:0] ALU_ADD_PC = 4'd11;

   // Counter only needs to reach TIMEOUT-1: the TIMEOUT-th waiting cycle triggers the trap.
   localparam int WAIT_W = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);
   localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
   } state_t;

   state_t            state_q, state_d;
   logic [6:0]        opcode_q, opcode_d;
   logic [4:0]        rd_q, rd_d;
   logic [2:0]        funct3_q, funct3_d;
   logic              f7b5_q, f7b5_d;
   logic [WAIT_W-1:0] wait_q, wait_d;
   logic [CNT_W-1:0]  instret_q, instret_d;
   logic              retire;
   logic              legal;
   logic              unused_instr;

   // Register operand fields are consumed by the datapath, not by the sequencer.
   assign unused_instr = ^{instr[31], instr[29:15]};

   // Opcode legality of the latched instruction; branch funct3 010/011 do not exist.
   always_comb begin
      legal = 1'b0;
      case (opcode_q)
         OP_R, OP_IMM, OP_LOAD, OP_STORE, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC: legal = 1'b1;
         OP_BRANCH: legal = (funct3_q[2:1] != 2'b01);
         default:   legal = 1'b0;
      endcase
   end

   // State, latched fields, wait counter and retire counter; reset aborts everything.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= S_FETCH;
         opcode_q  <= '0;
         rd_q      <= '0;
         funct3_q  <= '0;
         f7b5_q    <= 1'b0;
         wait_q    <= '0;
         instret_q <= '0;
      end else begin
         state_q   <= state_d;
         opcode_q  <= opcode_d;
         rd_q      <= rd_d;
         funct3_q  <= funct3_d;
         f7b5_q    <= f7b5_d;
         wait_q    <= wait_d;
         instret_q <= instret_d;
      end
   end

   // Next state; the wait counter is zero unless staying in FETCH/MEM without ready.
   always_comb begin
      state_d  = state_q;
      opcode_d = opcode_q;
      rd_d     = rd_q;
      funct3_d = funct3_q;
      f7b5_d   = f7b5_q;
      wait_d   = '0;
      retire   = 1'b0;
      case (state_q)
         S_FETCH: begin
            if (imem_ready) begin
               opcode_d = instr[6:0];
               rd_d     = instr[11:7];
               funct3_d = instr[14:12];
               f7b5_d   = instr[30];
               state_d  = S_DECODE;
            end else if (TIMEOUT != 0) begin
               if (wait_q == WAIT_LAST) state_d = S_TRAP;
               else                     wait_d  = wait_q + 1'b1;
            end
         end
         S_DECODE: begin
            if (legal) begin
               state_d = S_EXEC;
            end else if (TRAP_ON_ILLEGAL) begin
               state_d = S_TRAP;
            end else begin
               retire  = 1'b1;
               state_d = S_FETCH;
            end
         end
         S_EXEC: begin
            case (opcode_q)
               OP_LOAD, OP_STORE: state_d = S_MEM;
               OP_BRANCH: begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
               default:   state_d = S_WB;
            endcase
         end
         S_MEM: begin
            if (dmem_ready) begin
               if (opcode_q == OP_LOAD) begin
                  state_d = S_WB;
               end else begin
                  retire  = 1'b1;
                  state_d = S_FETCH;
               end
            end else if (TIMEOUT != 0) begin
               if (wait_q == WAIT_LAST) state_d = S_TRAP;
               else                     wait_d  = wait_q + 1'b1;
            end
         end
         S_WB: begin
            retire  = 1'b1;
            state_d = S_FETCH;
         end
         default: state_d = S_TRAP;
      endcase
      instret_d = instret_q + {{(CNT_W-1){1'b0}}, retire};
   end

   // Control outputs from state and latched fields; all forced low while rst is asserted.
   always_comb begin
      imem_req    = 1'b0;
      dmem_req    = 1'b0;
      ir_write    = 1'b0;
      mem_read    = 1'b0;
      mem_write   = 1'b0;
      alu_ctrl    = ALU_ADD;
      alu_src     = 1'b0;
      branch_ctrl = 3'd0;
      wb_sel      = 2'b00;
      reg_write   = 1'b0;
      pc_write    = 1'b0;
      pc_sel      = 2'b00;
      busy        = 1'b0;
      trap        = 1'b0;
      instret     = '0;
      if (!rst) begin
         instret = instret_q;
         case (state_q)
            S_FETCH: begin
               imem_req = 1'b1;
               ir_write = imem_ready;
               busy     = imem_ready;
            end
            S_DECODE: begin
               busy     = 1'b1;
               pc_write = !legal && !TRAP_ON_ILLEGAL;
            end
            S_EXEC: begin
               busy = 1'b1;
               case (opcode_q)
                  OP_R, OP_IMM: begin
                     alu_src = (opcode_q == OP_IMM);
                     case (funct3_q)
                        3'b000:  alu_ctrl = (opcode_q == OP_R && f7b5_q) ? ALU_SUB : ALU_ADD;
                        3'b001:  alu_ctrl = ALU_SLL;
                        3'b010:  alu_ctrl = ALU_SLT;
                        3'b011:  alu_ctrl = ALU_SLTU;
                        3'b100:  alu_ctrl = ALU_XOR;
                        3'b101:  alu_ctrl = f7b5_q ? ALU_SRA : ALU_SRL;
                        3'b110:  alu_ctrl = ALU_OR;
                        default: alu_ctrl = ALU_AND;
                     endcase
                  end
                  OP_BRANCH: begin
                     case (funct3_q[2:1])
                        2'b00:   alu_ctrl = ALU_SUB;
                        2'b10:   alu_ctrl = ALU_SLT;
                        default: alu_ctrl = ALU_SLTU;
                     endcase
                     branch_ctrl = funct3_q[2] ? {1'b0, funct3_q[1:0]} + 3'd2 : {2'b00, funct3_q[0]};
                     pc_write    = 1'b1;
                     pc_sel      = branch_taken ? 2'b01 : 2'b00;
                  end
                  OP_LUI: begin
                     alu_ctrl = ALU_PASS;
                     alu_src  = 1'b1;
                  end
                  OP_AUIPC, OP_JAL: begin
                     alu_ctrl = ALU_ADD_PC;
                     alu_src  = 1'b1;
                  end
                  default: begin
                     alu_ctrl = ALU_ADD;
                     alu_src  = 1'b1;
                  end
               endcase
            end
            S_MEM: begin
               busy      = 1'b1;
               dmem_req  = 1'b1;
               mem_read  = (opcode_q == OP_LOAD);
               mem_write = (opcode_q == OP_STORE);
               pc_write  = (opcode_q == OP_STORE) && dmem_ready;
            end
            S_WB: begin
               busy      = 1'b1;
               reg_write = (rd_q != 5'd0);
               pc_write  = 1'b1;
               case (opcode_q)
                  OP_LOAD: wb_sel = 2'b01;
                  OP_JAL:  begin wb_sel = 2'b10; pc_sel = 2'b01; end
                  OP_JALR: begin wb_sel = 2'b10; pc_sel = 2'b10; end
                  default: wb_sel = 2'b00;
               endcase
            end
            default: begin
               busy = 1'b1;
               trap = 1'b1;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_multicycle_control_fsm.sv
// Directed bench for multicycle_control_fsm with TIMEOUT=4 so memory waits hit the timeout edge.
// Inputs change at the falling edge; outputs are checked 1 time unit later.
// Expected values are hand-computed from the instruction encodings.
module tb_multicycle_control_fsm;

   logic        clk;
   logic        rst;
   logic [31:0] instr;
   logic        imem_ready;
   logic        dmem_ready;
   logic        branch_taken;
   logic        imem_req;
   logic        dmem_req;
   logic        ir_write;
   logic        mem_read;
   logic        mem_write;
   logic [3:0]  alu_ctrl;
   logic        alu_src;
   logic [2:0]  branch_ctrl;
   logic [1:0]  wb_sel;
   logic        reg_write;
   logic        pc_write;
   logic [1:0]  pc_sel;
   logic        busy;
   logic        trap;
   logic [31:0] instret;

   int n_cmp = 0;
   int n_err = 0;
   int exp_ret = 0;

   localparam logic [31:0] I_ADDI  = 32'h0050_0093; // addi x1,x0,5
   localparam logic [31:0] I_LW    = 32'h0000_A103; // lw   x2,0(x1)
   localparam logic [31:0] I_BEQ   = 32'h0020_8463; // beq  x1,x2,+8
   localparam logic [31:0] I_BGE   = 32'h0020_D463; // bge  x1,x2,+8
   localparam logic [31:0] I_ADD0  = 32'h0020_8033; // add  x0,x1,x2
   localparam logic [31:0] I_SUB   = 32'h4020_81B3; // sub  x3,x1,x2
   localparam logic [31:0] I_SRAI  = 32'h4030_D293; // srai x5,x1,3
   localparam logic [31:0] I_JALR  = 32'h0001_00E7; // jalr x1,0(x2)
   localparam logic [31:0] I_SW    = 32'h0020_A223; // sw   x2,4(x1)
   localparam logic [31:0] I_ILL   = 32'h0000_007F; // opcode 0x7F
   localparam logic [31:0] I_BILL  = 32'h0000_2063; // branch funct3 010

   multicycle_control_fsm #(.TIMEOUT(4), .CNT_W(32), .TRAP_ON_ILLEGAL(1'b1)) dut (
      .clk          (clk),
      .rst          (rst),
      .instr        (instr),
      .imem_ready   (imem_ready),
      .dmem_ready   (dmem_ready),
      .branch_taken (branch_taken),
      .imem_req     (imem_req),
      .dmem_req     (dmem_req),
      .ir_write     (ir_write),
      .mem_read     (mem_read),
      .mem_write    (mem_write),
      .alu_ctrl     (alu_ctrl),
      .alu_src      (alu_src),
      .branch_ctrl  (branch_ctrl),
      .wb_sel       (wb_sel),
      .reg_write    (reg_write),
      .pc_write     (pc_write),
      .pc_sel       (pc_sel),
      .busy         (busy),
      .trap         (trap),
      .instret      (instret)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // One clock cycle: drive inputs at the falling edge, settle, then the caller checks.
   task automatic cyc(input logic ir, input logic dr, input logic [31:0] ins, input logic bt);
      @(negedge clk);
      imem_ready   = ir;
      dmem_ready   = dr;
      instr        = ins;
      branch_taken = bt;
      #1;
   endtask

   // Accept an instruction in FETCH and step through DECODE.
   task automatic fetch_decode(input logic [31:0] ins);
      cyc(1'b1, 1'b0, ins, 1'b0);
      chk_eq("fetch_ir_write", ir_write, 1);
      chk_eq("fetch_instret", instret, exp_ret);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("decode_busy", busy, 1);
      chk_eq("decode_imem_req", imem_req, 0);
   endtask

   task automatic do_reset();
      rst = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      exp_ret = 0;
      rst = 1'b0;
   endtask

   initial begin
      rst = 1'b1; instr = '0; imem_ready = 1'b0; dmem_ready = 1'b0; branch_taken = 1'b0;
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("rst_imem_req", imem_req, 0);
      chk_eq("rst_busy", busy, 0);
      chk_eq("rst_trap", trap, 0);
      chk_eq("rst_instret", instret, 0);
      chk_eq("rst_pc_write", pc_write, 0);
      rst = 1'b0;

      // addi: FETCH, DECODE, EXEC, WB
      fetch_decode(I_ADDI);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("addi_alu", alu_ctrl, 0);
      chk_eq("addi_src", alu_src, 1);
      chk_eq("addi_exec_pcw", pc_write, 0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("addi_regw", reg_write, 1);
      chk_eq("addi_wbsel", wb_sel, 0);
      chk_eq("addi_pcsel", pc_sel, 0);
      chk_eq("addi_pcw", pc_write, 1);
      exp_ret++;

      // lw with dmem_ready arriving on the 4th MEM cycle (coincides with timeout)
      fetch_decode(I_LW);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("lw_alu", alu_ctrl, 0);
      chk_eq("lw_src", alu_src, 1);
      for (int i = 0; i < 3; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0);
         chk_eq("lw_wait_dmem_req", dmem_req, 1);
         chk_eq("lw_wait_mem_read", mem_read, 1);
         chk_eq("lw_wait_pcw", pc_write, 0);
      end
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk_eq("lw_rdy_mem_read", mem_read, 1);
      chk_eq("lw_rdy_trap", trap, 0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("lw_wbsel", wb_sel, 1);
      chk_eq("lw_regw", reg_write, 1);
      chk_eq("lw_dmem_req", dmem_req, 0);
      exp_ret++;

      // beq taken
      fetch_decode(I_BEQ);
      cyc(1'b0, 1'b0, 32'h0, 1'b1);
      chk_eq("beq_alu", alu_ctrl, 1);
      chk_eq("beq_brc", branch_ctrl, 0);
      chk_eq("beq_pcsel", pc_sel, 1);
      chk_eq("beq_pcw", pc_write, 1);
      chk_eq("beq_regw", reg_write, 0);
      exp_ret++;

      // bge not taken
      fetch_decode(I_BGE);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("bge_alu", alu_ctrl, 8);
      chk_eq("bge_brc", branch_ctrl, 3);
      chk_eq("bge_pcsel", pc_sel, 0);
      chk_eq("bge_pcw", pc_write, 1);
      exp_ret++;

      // add x0: no register write
      fetch_decode(I_ADD0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("add_alu", alu_ctrl, 0);
      chk_eq("add_src", alu_src, 0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("add_x0_regw", reg_write, 0);
      chk_eq("add_x0_pcw", pc_write, 1);
      exp_ret++;

      fetch_decode(I_SUB);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("sub_alu", alu_ctrl, 1);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("sub_regw", reg_write, 1);
      exp_ret++;

      fetch_decode(I_SRAI);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("srai_alu", alu_ctrl, 7);
      chk_eq("srai_src", alu_src, 1);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      exp_ret++;

      fetch_decode(I_JALR);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("jalr_wbsel", wb_sel, 2);
      chk_eq("jalr_pcsel", pc_sel, 2);
      chk_eq("jalr_regw", reg_write, 1);
      exp_ret++;

      // sw with immediate dmem_ready: retires from MEM
      fetch_decode(I_SW);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b1, 32'h0, 1'b0);
      chk_eq("sw_mem_write", mem_write, 1);
      chk_eq("sw_mem_read", mem_read, 0);
      chk_eq("sw_pcw", pc_write, 1);
      chk_eq("sw_dmem_req", dmem_req, 1);
      exp_ret++;

      // FETCH wait: ready on the 4th wait cycle wins over the timeout
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("idle_busy", busy, 0);
      chk_eq("idle_imem_req", imem_req, 1);
      chk_eq("idle_instret", instret, exp_ret);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("wait3_trap", trap, 0);
      fetch_decode(I_ADDI);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      exp_ret++;

      // FETCH timeout: 4 wait cycles then TRAP
      for (int i = 0; i < 4; i++) begin
         cyc(1'b0, 1'b0, 32'h0, 1'b0);
         chk_eq("to_wait_trap", trap, 0);
         chk_eq("to_wait_imem_req", imem_req, 1);
      end
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("to_trap", trap, 1);
      chk_eq("to_trap_busy", busy, 1);
      chk_eq("to_trap_imem_req", imem_req, 0);
      chk_eq("to_trap_instret", instret, exp_ret);
      do_reset();
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("post_to_rst_trap", trap, 0);
      chk_eq("post_to_rst_imem_req", imem_req, 1);
      chk_eq("post_to_rst_instret", instret, 0);

      // Illegal opcode traps after DECODE and stays trapped
      fetch_decode(I_ILL);
      chk_eq("ill_decode_trap", trap, 0);
      for (int i = 0; i < 200; i++) cyc(1'b1, 1'b1, I_ADDI, 1'b1);
      chk_eq("ill_trap_sticky", trap, 1);
      chk_eq("ill_imem_req", imem_req, 0);
      chk_eq("ill_regw", reg_write, 0);
      chk_eq("ill_pcw", pc_write, 0);
      chk_eq("ill_instret", instret, 0);
      do_reset();
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("ill_rst_trap", trap, 0);
      chk_eq("ill_rst_imem_req", imem_req, 1);

      // Branch with funct3 010 is illegal
      fetch_decode(I_BILL);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("bill_trap", trap, 1);
      chk_eq("bill_pcw", pc_write, 0);
      do_reset();

      // Reset in the middle of a load's MEM wait
      fetch_decode(I_LW);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("mid_mem_dmem_req", dmem_req, 1);
      rst = 1'b1;
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("mid_rst_dmem_req", dmem_req, 0);
      chk_eq("mid_rst_mem_read", mem_read, 0);
      rst = 1'b0;
      cyc(1'b0, 1'b0, 32'h0, 1'b0);
      chk_eq("mid_rst_fetch", imem_req, 1);
      chk_eq("mid_rst_dmem_after", dmem_req, 0);
      chk_eq("mid_rst_instret", instret, 0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
